// File: rtl/uart_rx_fifo.sv
// rtl/uart_rx_fifo.sv - 8N1 UART receiver feeding a first-word-fall-through byte FIFO

module uart_rx_fifo_buf #(
    parameter int DEPTH = 16
) (
    input  logic                     ap_clk,
    input  logic                     ap_rst,
    input  logic [7:0]               s_tdata,
    input  logic                     s_tvalid,
    output logic                     s_drop,
    output logic [7:0]               m_tdata,
    output logic                     m_tvalid,
    input  logic                     m_tready,
    output logic [$clog2(DEPTH):0]   count
);
    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;
    localparam logic [CW-1:0] FULL_CNT = CW'(DEPTH);

    logic [7:0]    mem [DEPTH];
    logic [AW-1:0] wr_ptr;
    logic [AW-1:0] rd_ptr;
    logic          pop;
    logic          push_ok;

    assign m_tvalid = (count != '0);
    assign pop      = m_tvalid && m_tready;
    // A full buffer still accepts a byte when the head leaves in the same cycle.
    assign push_ok  = s_tvalid && ((count != FULL_CNT) || pop);
    assign s_drop   = s_tvalid && !push_ok;
    assign m_tdata  = m_tvalid ? mem[rd_ptr] : 8'h00;

    always_ff @(posedge ap_clk or posedge ap_rst) begin
        if (ap_rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push_ok) wr_ptr <= wr_ptr + AW'(1);
            if (pop)     rd_ptr <= rd_ptr + AW'(1);
            case ({push_ok, pop})
                2'b10:   count <= count + CW'(1);
                2'b01:   count <= count - CW'(1);
                default: count <= count;
            endcase
        end
    end

    always_ff @(posedge ap_clk) begin
        if (push_ok) mem[wr_ptr] <= s_tdata;
    end
endmodule

module uart_rx_fifo #(
    parameter int BAUD_DIV   = 4167,
    parameter int FIFO_DEPTH = 16
) (
    input  logic                          ap_clk,
    input  logic                          ap_rst,
    input  logic                          rx,
    output logic [7:0]                    rx_data,
    output logic                          rx_valid,
    input  logic                          rx_ready,
    output logic [$clog2(FIFO_DEPTH):0]   fifo_count,
    output logic                          frame_err,
    output logic                          overrun,
    output logic [1:0]                    err_sticky,
    input  logic                          err_clr
);
    localparam int CNT_W = $clog2(BAUD_DIV);
    localparam logic [CNT_W-1:0] FULL_BIT = CNT_W'(BAUD_DIV - 1);
    localparam logic [CNT_W-1:0] HALF_BIT = CNT_W'(BAUD_DIV / 2 - 1);

    typedef enum logic [2:0] {IDLE, START, DATA, STOP, WAIT_IDLE} state_t;

    state_t           state, state_nxt;
    logic             rx_meta, rxs;
    logic [CNT_W-1:0] cnt, cnt_nxt;
    logic [2:0]       idx, idx_nxt;
    logic [7:0]       shreg, shreg_nxt;
    logic             push, bad_stop, drop;

    always_comb begin
        state_nxt = state;
        cnt_nxt   = cnt;
        idx_nxt   = idx;
        shreg_nxt = shreg;
        push      = 1'b0;
        bad_stop  = 1'b0;
        case (state)
            IDLE: begin
                if (!rxs) begin
                    state_nxt = START;
                    cnt_nxt   = HALF_BIT;
                end
            end
            START: begin
                if (cnt != '0) begin
                    cnt_nxt = cnt - CNT_W'(1);
                end else if (!rxs) begin
                    state_nxt = DATA;
                    cnt_nxt   = FULL_BIT;
                    idx_nxt   = 3'd0;
                end else begin
                    state_nxt = IDLE;
                end
            end
            DATA: begin
                if (cnt != '0) begin
                    cnt_nxt = cnt - CNT_W'(1);
                end else begin
                    shreg_nxt[idx] = rxs;
                    cnt_nxt        = FULL_BIT;
                    idx_nxt        = idx + 3'd1;
                    if (idx == 3'd7) state_nxt = STOP;
                end
            end
            STOP: begin
                if (cnt != '0) begin
                    cnt_nxt = cnt - CNT_W'(1);
                end else if (rxs) begin
                    push      = 1'b1;
                    state_nxt = IDLE;
                end else begin
                    bad_stop  = 1'b1;
                    state_nxt = WAIT_IDLE;
                end
            end
            // A held-low line (break) must go high before another start bit counts.
            WAIT_IDLE: begin
                if (rxs) state_nxt = IDLE;
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge ap_clk or posedge ap_rst) begin
        if (ap_rst) begin
            rx_meta    <= 1'b1;
            rxs        <= 1'b1;
            state      <= IDLE;
            cnt        <= '0;
            idx        <= 3'd0;
            shreg      <= 8'h00;
            frame_err  <= 1'b0;
            overrun    <= 1'b0;
            err_sticky <= 2'b00;
        end else begin
            rx_meta    <= rx;
            rxs        <= rx_meta;
            state      <= state_nxt;
            cnt        <= cnt_nxt;
            idx        <= idx_nxt;
            shreg      <= shreg_nxt;
            frame_err  <= bad_stop;
            overrun    <= drop;
            err_sticky <= (err_clr ? 2'b00 : err_sticky) | {drop, bad_stop};
        end
    end

    uart_rx_fifo_buf #(.DEPTH(FIFO_DEPTH)) u_buf (
        .ap_clk   (ap_clk),
        .ap_rst   (ap_rst),
        .s_tdata  (shreg),
        .s_tvalid (push),
        .s_drop   (drop),
        .m_tdata  (rx_data),
        .m_tvalid (rx_valid),
        .m_tready (rx_ready),
        .count    (fifo_count)
    );
endmodule

// File: tb/tb_uart_rx_fifo.sv
// tb/tb_uart_rx_fifo.sv - randomized self-checking bench for uart_rx_fifo against a queue model

module tb_uart_rx_fifo;
    localparam int B = 16;
    localparam int H = B / 2;
    localparam int D = 16;

    logic       ap_clk = 1'b0;
    logic       ap_rst = 1'b0;
    logic       rx = 1'b1;
    logic       rx_ready = 1'b0;
    logic       err_clr = 1'b0;
    logic [7:0] rx_data;
    logic       rx_valid;
    logic [4:0] fifo_count;
    logic       frame_err;
    logic       overrun;
    logic [1:0] err_sticky;

    uart_rx_fifo #(.BAUD_DIV(B), .FIFO_DEPTH(D)) dut (
        .ap_clk     (ap_clk),
        .ap_rst     (ap_rst),
        .rx         (rx),
        .rx_data    (rx_data),
        .rx_valid   (rx_valid),
        .rx_ready   (rx_ready),
        .fifo_count (fifo_count),
        .frame_err  (frame_err),
        .overrun    (overrun),
        .err_sticky (err_sticky),
        .err_clr    (err_clr)
    );

    always #5 ap_clk = ~ap_clk;

    typedef struct {
        int         at;
        logic [7:0] b;
        bit         good;
    } ev_t;

    ev_t        evq[$];
    logic [7:0] mq[$];
    logic [7:0] got[$];
    logic [7:0] exp_bytes[$];
    int         cyc = 0;
    bit         m_fe = 0;
    bit         m_ovr = 0;
    logic [1:0] m_sticky = 2'b00;
    int         checks = 0;
    int         failures = 0;
    int         fe_cnt = 0;
    int         ov_cnt = 0;
    int         max_cnt = 0;
    int         rdy_mode = 0;
    logic       rdy_val = 1'b0;
    bit         clr_req = 0;
    bit         arm_clr = 0;
    int         clr_at = -1;

    function automatic void chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            failures++;
            $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
        end
    endfunction

    // Frame completion is scheduled from the line timing: 2 sync flops, one
    // cycle to leave IDLE, half a bit to mid-start, then 9 full bits.
    initial begin : model
        bit         pop;
        bit         has_push;
        logic [7:0] pb;
        forever begin
            @(posedge ap_clk);
            cyc++;
            m_fe  = 0;
            m_ovr = 0;
            if (!ap_rst) begin
                pop      = (mq.size() != 0) && rx_ready;
                has_push = 0;
                pb       = 8'h00;
                while (evq.size() != 0 && evq[0].at <= cyc) begin
                    if (evq[0].at == cyc) begin
                        if (evq[0].good) begin
                            has_push = 1;
                            pb       = evq[0].b;
                        end else begin
                            m_fe = 1;
                        end
                    end
                    void'(evq.pop_front());
                end
                if (pop) void'(mq.pop_front());
                if (has_push) begin
                    if (mq.size() < D) mq.push_back(pb);
                    else m_ovr = 1;
                end
                m_sticky = (err_clr ? 2'b00 : m_sticky) | {m_ovr, m_fe};
            end
        end
    end

    initial begin : compare
        forever begin
            @(negedge ap_clk);
            #1;
            chk("rx_valid", int'(rx_valid), int'(mq.size() != 0));
            chk("fifo_count", int'(fifo_count), mq.size());
            chk("rx_data", int'(rx_data), (mq.size() != 0) ? int'(mq[0]) : 0);
            chk("frame_err", int'(frame_err), int'(m_fe));
            chk("overrun", int'(overrun), int'(m_ovr));
            chk("err_sticky", int'(err_sticky), int'(m_sticky));
            if (rx_valid && rx_ready) got.push_back(rx_data);
            if (frame_err) fe_cnt++;
            if (overrun) ov_cnt++;
            if (int'(fifo_count) > max_cnt) max_cnt = int'(fifo_count);
        end
    end

    initial begin : drivers
        forever begin
            @(negedge ap_clk);
            case (rdy_mode)
                0:       rx_ready = rdy_val;
                1:       rx_ready = ~rx_ready;
                default: rx_ready = 1'($urandom_range(0, 1));
            endcase
            err_clr = clr_req || (cyc + 1 == clr_at);
        end
    end

    task automatic idle(input int n);
        repeat (n) @(negedge ap_clk);
    endtask

    task automatic clear_stats();
        got.delete();
        fe_cnt  = 0;
        ov_cnt  = 0;
        max_cnt = 0;
    endtask

    task automatic send_frame(input logic [7:0] b, input bit stop_ok);
        @(negedge ap_clk);
        evq.push_back('{at: cyc + 3 + H + 9 * B, b: b, good: stop_ok});
        if (arm_clr) begin
            clr_at  = cyc + 3 + H + 9 * B;
            arm_clr = 0;
        end
        rx = 1'b0;
        repeat (B) @(negedge ap_clk);
        for (int i = 0; i < 8; i++) begin
            rx = b[i];
            repeat (B) @(negedge ap_clk);
        end
        rx = stop_ok;
        repeat (B) @(negedge ap_clk);
    endtask

    initial begin : main
        #1 ap_rst = 1'b1;
        #2;
        chk("rst_rx_data", int'(rx_data), 0);
        chk("rst_rx_valid", int'(rx_valid), 0);
        chk("rst_fifo_count", int'(fifo_count), 0);
        chk("rst_err_sticky", int'(err_sticky), 0);
        idle(4);
        ap_rst = 1'b0;
        idle(5);

        clear_stats();
        rdy_val = 1'b1;
        send_frame(8'hA5, 1);
        idle(30);
        chk("a5_count", got.size(), 1);
        if (got.size() > 0) chk("a5_byte", int'(got[0]), 'hA5);
        chk("a5_frame_err", fe_cnt, 0);
        chk("a5_overrun", ov_cnt, 0);

        clear_stats();
        rx = 1'b0;
        idle(3);
        rx = 1'b1;
        idle(30);
        chk("glitch_bytes", got.size(), 0);
        chk("glitch_errs", fe_cnt + ov_cnt, 0);

        clear_stats();
        send_frame(8'h3C, 0);
        idle(40);
        rx = 1'b1;
        idle(20);
        chk("ferr_pulses", fe_cnt, 1);
        chk("ferr_sticky", int'(err_sticky), 1);
        chk("ferr_bytes", got.size(), 0);
        send_frame(8'h55, 1);
        idle(30);
        chk("ferr_next_count", got.size(), 1);
        if (got.size() > 0) chk("ferr_next_byte", int'(got[0]), 'h55);

        clear_stats();
        rdy_val = 1'b0;
        idle(2);
        for (int i = 0; i < 17; i++) begin
            if (i == 16) arm_clr = 1;
            send_frame(8'(i), 1);
        end
        idle(30);
        chk("ovr_fifo_count", int'(fifo_count), 16);
        chk("ovr_pulses", ov_cnt, 1);
        chk("ovr_sticky", int'(err_sticky), 2);
        chk("ovr_no_pop", got.size(), 0);
        rdy_val = 1'b1;
        idle(40);
        chk("ovr_drain_count", got.size(), 16);
        for (int i = 0; i < got.size() && i < 16; i++) chk("ovr_drain_order", int'(got[i]), i);
        clr_req = 1;
        idle(2);
        clr_req = 0;
        idle(2);
        chk("clr_sticky", int'(err_sticky), 0);

        rdy_val = 1'b0;
        send_frame(8'h99, 1);
        idle(5);
        @(negedge ap_clk);
        rx = 1'b0;
        idle(B);
        rx = 1'b1;
        idle(3 * B);
        ap_rst = 1'b1;
        evq.delete();
        mq.delete();
        m_sticky = 2'b00;
        m_fe = 0;
        m_ovr = 0;
        #2;
        chk("midrst_rx_valid", int'(rx_valid), 0);
        chk("midrst_rx_data", int'(rx_data), 0);
        chk("midrst_fifo_count", int'(fifo_count), 0);
        idle(3);
        ap_rst = 1'b0;
        clear_stats();
        rdy_val = 1'b1;
        idle(7 * B);
        send_frame(8'h42, 1);
        idle(30);
        chk("midrst_count", got.size(), 1);
        if (got.size() > 0) chk("midrst_byte", int'(got[0]), 'h42);

        clear_stats();
        rdy_mode = 1;
        send_frame(8'h41, 1);
        send_frame(8'h42, 1);
        idle(30);
        chk("b2b_count", got.size(), 2);
        if (got.size() > 1) begin
            chk("b2b_first", int'(got[0]), 'h41);
            chk("b2b_second", int'(got[1]), 'h42);
        end
        chk("b2b_max_le2", int'(max_cnt <= 2), 1);

        clear_stats();
        exp_bytes.delete();
        rdy_mode = 2;
        for (int n = 0; n < 20; n++) begin
            logic [7:0] b;
            bit         ok;
            b  = 8'($urandom_range(0, 255));
            ok = ($urandom_range(0, 4) != 0);
            send_frame(b, ok);
            if (ok) begin
                exp_bytes.push_back(b);
            end else begin
                idle($urandom_range(0, 20));
                rx = 1'b1;
                idle(3);
            end
            idle($urandom_range(0, 12));
        end
        rdy_mode = 0;
        rdy_val  = 1'b1;
        idle(40);
        chk("rand_count", got.size(), exp_bytes.size());
        for (int i = 0; i < got.size() && i < exp_bytes.size(); i++)
            chk("rand_byte", int'(got[i]), int'(exp_bytes[i]));

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule

// File: doc/uart_rx_fifo.md
UART_RX_FIFO -- requirements
Module: uart_rx_fifo

Interface
REQ-001 SHALL have parameter BAUD_DIV, default 4167, meaning ap_clk cycles per UART bit (40 MHz / 9600 baud).
REQ-002 SHALL have parameter FIFO_DEPTH, default 16, meaning received-byte buffer entries (power of two).
REQ-003 SHALL have port ap_clk, input, 1, the single clock for all state.
REQ-004 SHALL have port ap_rst, input, 1, asynchronous active-high reset.
REQ-005 SHALL have port rx, input, 1, asynchronous serial line, idle high, 8N1 LSB-first.
REQ-006 SHALL have port rx_data, output, 8, head-of-FIFO byte.
REQ-007 SHALL have port rx_valid, output, 1, FIFO non-empty.
REQ-008 SHALL have port rx_ready, input, 1, consumer accepts head byte.
REQ-009 SHALL have port fifo_count, output, log2(FIFO_DEPTH)+1, current occupancy.
REQ-010 SHALL have port frame_err, output, 1, one-cycle pulse on bad stop bit.
REQ-011 SHALL have port overrun, output, 1, one-cycle pulse on push into a full FIFO.
REQ-012 SHALL have port err_sticky, output, 2, {overrun, frame} latched flags.
REQ-013 SHALL have port err_clr, input, 1, clears err_sticky.

Function
REQ-014 SHALL pass rx through a 2-flop synchronizer (reset value 1); all line decisions use the synchronized value rxs.
REQ-015 SHALL implement states IDLE, START, DATA, STOP, WAIT_IDLE with one bit counter (0..BAUD_DIV-1) and a 3-bit bit index.
REQ-016 IDLE: rxs==0 SHALL enter START and load the counter for BAUD_DIV/2 (floor) cycles.
REQ-017 START: at expiry, rxs==0 SHALL enter DATA with index 0; rxs==1 SHALL treat it as a glitch and return to IDLE with no output.
REQ-018 DATA: every BAUD_DIV cycles SHALL sample rxs into shift-register bit [index], LSB first; after index 7 SHALL enter STOP.
REQ-019 STOP: after BAUD_DIV cycles, rxs==1 SHALL push the byte and return to IDLE; rxs==0 SHALL pulse frame_err, drop the byte and enter WAIT_IDLE.
REQ-020 WAIT_IDLE SHALL return to IDLE only once rxs==1 (break conditions do not re-trigger).
REQ-021 The pushed byte SHALL appear at rx_data with rx_valid=1 on the cycle after the stop-bit sample cycle (FIFO previously empty).
REQ-022 FIFO SHALL be first-word-fall-through; a pop occurs on rx_valid && rx_ready.
REQ-023 The push SHALL be accepted if the FIFO is not full, or is full with a pop in the same cycle; otherwise the byte is dropped and overrun pulses.
REQ-024 A simultaneous push and pop SHALL leave fifo_count unchanged; pointers wrap modulo FIFO_DEPTH.
REQ-025 err_sticky bits SHALL set on their pulses; err_clr clears them; a set and a clear in the same cycle SHALL leave the bit set.
REQ-026 rx_ready while rx_valid=0 SHALL have no effect.
REQ-027 rx_data SHALL be held stable while rx_valid=1 and no pop occurs.

Reset
REQ-028 ap_rst=1 SHALL immediately force: state IDLE, synchronizer 1, FIFO empty, fifo_count 0, rx_valid 0, rx_data 8'h00, frame_err 0, overrun 0, err_sticky 2'b00.
REQ-029 Reset asserted mid-frame SHALL discard the partial byte; after release, reception SHALL restart only on a new falling edge.

Verification (bench uses BAUD_DIV=16, FIFO_DEPTH=16)
REQ-030 Send 0xA5 with rx_ready=1 -> exactly one rx_valid with rx_data=0xA5; frame_err=0; overrun=0.
REQ-031 rx low for 3 cycles, then high -> no rx_valid, no error pulse, state back to IDLE.
REQ-032 Send 0x3C with stop bit 0, then hold low for 40 cycles -> frame_err pulses once, err_sticky=2'b01, no byte; then send 0x55 -> 0x55 received.
REQ-033 rx_ready=0, send 17 bytes 0x00..0x10 -> fifo_count=16, one overrun pulse on the 17th, err_sticky=2'b10; drain -> bytes 0x00..0x0F in order.
REQ-034 Assert ap_rst during DATA of 0xFF -> outputs at reset values; send 0x42 after release -> 0x42 only.
REQ-035 Back-to-back 0x41, 0x42 with rx_ready toggling every cycle -> both delivered in order; fifo_count never exceeds 2.
